// File: rtl/pio_pkg.sv
// Shared encodings for the PIO responder: request types, completion codes and FSM states.
package pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] REQ_MRD32 = 3'b000;
    localparam logic [2:0] REQ_MWR32 = 3'b001;
    localparam logic [2:0] REQ_MRD64 = 3'b010;
    localparam logic [2:0] REQ_MWR64 = 3'b011;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    localparam logic CPL_NODATA   = 1'b0;
    localparam logic CPL_WITHDATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_RD   = 2'd1,
        ST_CPL      = 2'd2,
        ST_CPL_WAIT = 2'd3
    } pio_state_t;

    function automatic logic is_read(input logic [2:0] t);
        return (t == REQ_MRD32) || (t == REQ_MRD64);
    endfunction

    function automatic logic is_write(input logic [2:0] t);
        return (t == REQ_MWR32) || (t == REQ_MWR64);
    endfunction

endpackage

// File: rtl/pio_bar_mem.sv
// Single-port BAR storage with a registered read port; contents are never reset.
module pio_bar_mem
    import pio_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pio_responder.sv
// PIO target for one 32-bit memory BAR: single-DW writes land in BAR memory,
// single-DW reads launch a completion; everything else is dropped or answered UR.
module pio_responder
    import pio_pkg::*;
#(
    parameter logic [31:0] BAR_A_BASE = 32'h1000_0000,
    parameter int          BAR_A_SIZE = 1024
) (
    input  logic        user_clk,
    input  logic        reset,
    input  logic        user_lnk_up,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [7:0]  req_tag,
    input  logic [15:0] req_rid,
    input  logic [63:0] req_addr,
    input  logic [10:0] req_length,
    input  logic [31:0] req_data,
    output logic        cpl_start,
    output logic        cpl_type,
    output logic [2:0]  cpl_status,
    output logic [7:0]  cpl_tag,
    output logic [15:0] cpl_rid,
    output logic [6:0]  cpl_lower_addr,
    output logic [31:0] cpl_data,
    input  logic        cpl_done,
    output logic [15:0] err_count
);

    localparam int          IDX_W   = $clog2(BAR_A_SIZE);
    localparam logic [32:0] BAR_END = {1'b0, BAR_A_BASE} + 33'(4 * BAR_A_SIZE);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    pio_state_t        state;
    logic              accept;
    logic              hit;
    logic [IDX_W-1:0]  index;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req_ready = (state == ST_IDLE) && user_lnk_up && !reset;
    assign accept    = req_valid && req_ready;

    // 33-bit compare so a window ending at 4 GiB cannot wrap.
    assign hit = (req_addr[63:32] == 32'd0)
              && ({1'b0, req_addr[31:0]} >= {1'b0, BAR_A_BASE})
              && ({1'b0, req_addr[31:0]} < BAR_END)
              && (req_length == 11'd1);

    assign index  = IDX_W'((req_addr[31:0] - BAR_A_BASE) >> 2);
    assign mem_we = accept && is_write(req_type) && hit;

    pio_bar_mem #(
        .DEPTH (BAR_A_SIZE),
        .ADDR_W(IDX_W)
    ) u_bar_mem (
        .clk  (user_clk),
        .we   (mem_we),
        .addr (index),
        .wdata(req_data),
        .rdata(mem_rdata)
    );

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cpl_start      <= 1'b0;
            cpl_type       <= CPL_NODATA;
            cpl_status     <= CPL_SC;
            cpl_tag        <= 8'd0;
            cpl_rid        <= 16'd0;
            cpl_lower_addr <= 7'd0;
            cpl_data       <= 32'd0;
            err_count      <= 16'd0;
        end else if (!user_lnk_up) begin
            state     <= ST_IDLE;
            cpl_start <= 1'b0;
        end else begin
            cpl_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_read(req_type)) begin
                            cpl_tag        <= req_tag;
                            cpl_rid        <= req_rid;
                            cpl_lower_addr <= req_addr[6:0];
                            if (hit) begin
                                state <= ST_MEM_RD;
                            end else begin
                                state      <= ST_CPL;
                                cpl_start  <= 1'b1;
                                cpl_type   <= CPL_NODATA;
                                cpl_status <= CPL_UR;
                                cpl_data   <= 32'd0;
                                err_count  <= sat_inc(err_count);
                            end
                        end else if (!(is_write(req_type) && hit)) begin
                            err_count <= sat_inc(err_count);
                        end
                    end
                end
                // Memory address was presented in the accept cycle; data is valid now.
                ST_MEM_RD: begin
                    state      <= ST_CPL;
                    cpl_start  <= 1'b1;
                    cpl_type   <= CPL_WITHDATA;
                    cpl_status <= CPL_SC;
                    cpl_data   <= mem_rdata;
                end
                ST_CPL: begin
                    state <= ST_CPL_WAIT;
                end
                ST_CPL_WAIT: begin
                    if (cpl_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_responder.sv
// Directed bench for pio_responder: writes, hit/UR reads, drop cases, link loss, reset and a full sweep.
module tb_pio_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        user_clk = 1'b0;
    logic        reset;
    logic        user_lnk_up;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [7:0]  req_tag;
    logic [15:0] req_rid;
    logic [63:0] req_addr;
    logic [10:0] req_length;
    logic [31:0] req_data;
    logic        cpl_start;
    logic        cpl_type;
    logic [2:0]  cpl_status;
    logic [7:0]  cpl_tag;
    logic [15:0] cpl_rid;
    logic [6:0]  cpl_lower_addr;
    logic [31:0] cpl_data;
    logic        cpl_done;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 user_clk = ~user_clk;

    pio_responder #(
        .BAR_A_BASE(BASE),
        .BAR_A_SIZE(1024)
    ) dut (
        .user_clk      (user_clk),
        .reset         (reset),
        .user_lnk_up   (user_lnk_up),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_type      (req_type),
        .req_tag       (req_tag),
        .req_rid       (req_rid),
        .req_addr      (req_addr),
        .req_length    (req_length),
        .req_data      (req_data),
        .cpl_start     (cpl_start),
        .cpl_type      (cpl_type),
        .cpl_status    (cpl_status),
        .cpl_tag       (cpl_tag),
        .cpl_rid       (cpl_rid),
        .cpl_lower_addr(cpl_lower_addr),
        .cpl_data      (cpl_data),
        .cpl_done      (cpl_done),
        .err_count     (err_count)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] typ, input logic [63:0] addr, input logic [10:0] len,
                        input logic [31:0] data, input logic [7:0] tag, input logic [15:0] rid);
        @(negedge user_clk);
        req_valid  = 1'b1;
        req_type   = typ;
        req_addr   = addr;
        req_length = len;
        req_data   = data;
        req_tag    = tag;
        req_rid    = rid;
        chk("req_ready_at_send", req_ready, 1);
        @(posedge user_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_start(output int l);
        l = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge user_clk);
            if (cpl_start) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic check_cpl(input string name, input logic t, input logic [2:0] st,
                             input logic [7:0] tag, input logic [15:0] rid,
                             input logic [6:0] la, input logic [31:0] d);
        chk({name, "_type"}, cpl_type, t);
        chk({name, "_status"}, cpl_status, st);
        chk({name, "_tag"}, cpl_tag, tag);
        chk({name, "_rid"}, cpl_rid, rid);
        chk({name, "_lower_addr"}, cpl_lower_addr, la);
        chk({name, "_data"}, cpl_data, d);
    endtask

    task automatic finish_cpl();
        @(negedge user_clk);
        cpl_done = 1'b1;
        @(posedge user_clk);
        #1 cpl_done = 1'b0;
        @(negedge user_clk);
        chk("ready_after_done", req_ready, 1);
        chk("start_low_after_done", cpl_start, 0);
    endtask

    task automatic read_expect(input string name, input logic [2:0] typ, input logic [63:0] addr,
                               input logic [10:0] len, input logic [7:0] tag, input logic [15:0] rid,
                               input int exp_lat, input logic t, input logic [2:0] st,
                               input logic [31:0] d);
        int l;
        logic [6:0] la;
        la = addr[6:0];
        send(typ, addr, len, 32'd0, tag, rid);
        wait_start(l);
        chk({name, "_latency"}, l, exp_lat);
        check_cpl(name, t, st, tag, rid, la, d);
        finish_cpl();
    endtask

    task automatic no_start(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge user_clk);
            if (cpl_start) seen = 1'b1;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        user_lnk_up = 1'b1;
        req_valid   = 1'b0;
        req_type    = 3'b000;
        req_tag     = 8'd0;
        req_rid     = 16'd0;
        req_addr    = 64'd0;
        req_length  = 11'd0;
        req_data    = 32'd0;
        cpl_done    = 1'b0;

        // Reset state
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cpl_start", cpl_start, 0);
        check_cpl("rst", 1'b0, 3'd0, 8'd0, 16'd0, 7'd0, 32'd0);
        chk("rst_err_count", err_count, 0);
        reset = 1'b0;
        @(negedge user_clk);
        chk("ready_after_reset", req_ready, 1);

        // Write then immediate read of the same DW
        send(3'b001, {32'd0, BASE + 32'h10}, 11'd1, 32'hDEAD_BEEF, 8'h00, 16'h0000);
        read_expect("rd_deadbeef", 3'b000, {32'd0, BASE + 32'h10}, 11'd1, 8'h05, 16'h0100,
                    2, 1'b1, 3'b000, 32'hDEAD_BEEF);
        chk("err_after_rd", err_count, 0);

        // Just past the window
        read_expect("rd_past_end", 3'b000, {32'd0, BASE + 32'd4096}, 11'd1, 8'h07, 16'h0200,
                    1, 1'b0, 3'b001, 32'd0);
        chk("err_past_end", err_count, 1);

        // Last DW of the window, read via MemRd64
        send(3'b001, {32'd0, BASE + 32'hFFC}, 11'd1, 32'hCAFE_F00D, 8'h00, 16'h0000);
        read_expect("rd_last_dw", 3'b010, {32'd0, BASE + 32'hFFC}, 11'd1, 8'h08, 16'h0300,
                    2, 1'b1, 3'b000, 32'hCAFE_F00D);
        read_expect("rd_unaligned", 3'b000, {32'd0, BASE + 32'h13}, 11'd1, 8'h09, 16'h0301,
                    2, 1'b1, 3'b000, 32'hDEAD_BEEF);

        // Non-hit reads: below base, upper address bits set, length 2
        read_expect("rd_below", 3'b000, {32'd0, BASE - 32'd4}, 11'd1, 8'h0A, 16'h0400,
                    1, 1'b0, 3'b001, 32'd0);
        chk("err_below", err_count, 2);
        read_expect("rd_hi_addr", 3'b010, 64'h0000_0001_1000_0010, 11'd1, 8'h0B, 16'h0401,
                    1, 1'b0, 3'b001, 32'd0);
        chk("err_hi_addr", err_count, 3);
        read_expect("rd_len2", 3'b000, {32'd0, BASE + 32'h10}, 11'd2, 8'h0C, 16'h0402,
                    1, 1'b0, 3'b001, 32'd0);
        chk("err_len2", err_count, 4);

        // Dropped writes
        send(3'b001, {32'd0, BASE}, 11'd1, 32'hA5A5_A5A5, 8'h00, 16'h0000);
        send(3'b001, {32'd0, BASE}, 11'd2, 32'h1234_5678, 8'h00, 16'h0000);
        no_start("no_start_wr_len2", 4);
        chk("err_wr_len2", err_count, 5);
        read_expect("rd_after_len2", 3'b000, {32'd0, BASE}, 11'd1, 8'h0D, 16'h0500,
                    2, 1'b1, 3'b000, 32'hA5A5_A5A5);
        send(3'b100, {32'd0, BASE}, 11'd1, 32'h1111_1111, 8'h00, 16'h0000);
        no_start("no_start_unsup", 4);
        chk("err_unsup", err_count, 6);
        send(3'b011, {32'd0, BASE + 32'h8}, 11'd1, 32'h8888_8888, 8'h00, 16'h0000);
        read_expect("rd_mwr64", 3'b000, {32'd0, BASE + 32'h8}, 11'd1, 8'h0E, 16'h0501,
                    2, 1'b1, 3'b000, 32'h8888_8888);
        chk("err_mwr64", err_count, 6);

        // cpl_done with cpl_start is ignored; hold off with a pending request
        send(3'b000, {32'd0, BASE + 32'h10}, 11'd1, 32'd0, 8'h44, 16'hABCD);
        wait_start(lat);
        chk("hold_latency", lat, 2);
        cpl_done   = 1'b1;
        req_valid  = 1'b1;
        req_type   = 3'b001;
        req_addr   = {32'd0, BASE + 32'h40};
        req_length = 11'd1;
        req_data   = 32'h4040_4040;
        @(posedge user_clk);
        #1 cpl_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge user_clk);
            chk("hold_ready_low", req_ready, 0);
            chk("hold_start_low", cpl_start, 0);
            check_cpl("hold", 1'b1, 3'b000, 8'h44, 16'hABCD, 7'h10, 32'hDEAD_BEEF);
        end
        cpl_done = 1'b1;
        @(posedge user_clk);
        #1 cpl_done = 1'b0;
        @(negedge user_clk);
        chk("hold_ready_after_done", req_ready, 1);
        check_cpl("hold_after_done", 1'b1, 3'b000, 8'h44, 16'hABCD, 7'h10, 32'hDEAD_BEEF);
        @(posedge user_clk);
        #1 req_valid = 1'b0;
        read_expect("rd_held_write", 3'b000, {32'd0, BASE + 32'h40}, 11'd1, 8'h45, 16'hABCE,
                    2, 1'b1, 3'b000, 32'h4040_4040);

        // Link loss during ST_CPL_WAIT
        send(3'b001, {32'd0, BASE + 32'h20}, 11'd1, 32'h2020_2020, 8'h00, 16'h0000);
        send(3'b000, {32'd0, BASE + 32'h20}, 11'd1, 32'd0, 8'h46, 16'h0600);
        wait_start(lat);
        chk("lnk_latency", lat, 2);
        @(negedge user_clk);
        user_lnk_up = 1'b0;
        @(negedge user_clk);
        chk("lnk_down_ready", req_ready, 0);
        chk("lnk_down_start", cpl_start, 0);
        user_lnk_up = 1'b1;
        @(negedge user_clk);
        chk("lnk_up_ready_idle", req_ready, 1);
        no_start("lnk_no_start", 5);
        read_expect("lnk_rd_20", 3'b000, {32'd0, BASE + 32'h20}, 11'd1, 8'h47, 16'h0601,
                    2, 1'b1, 3'b000, 32'h2020_2020);
        read_expect("lnk_rd_10", 3'b000, {32'd0, BASE + 32'h10}, 11'd1, 8'h48, 16'h0602,
                    2, 1'b1, 3'b000, 32'hDEAD_BEEF);
        read_expect("lnk_rd_ffc", 3'b000, {32'd0, BASE + 32'hFFC}, 11'd1, 8'h49, 16'h0603,
                    2, 1'b1, 3'b000, 32'hCAFE_F00D);
        chk("lnk_err_kept", err_count, 6);

        // Reset mid-completion
        send(3'b000, {32'd0, BASE + 32'h10}, 11'd1, 32'd0, 8'h50, 16'h0700);
        wait_start(lat);
        chk("rst_mid_latency", lat, 2);
        reset = 1'b1;
        @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_start", cpl_start, 0);
        check_cpl("rst_mid", 1'b0, 3'd0, 8'd0, 16'd0, 7'd0, 32'd0);
        chk("rst_mid_err", err_count, 0);
        reset = 1'b0;
        @(negedge user_clk);
        chk("rst_mid_ready_after", req_ready, 1);

        // Full sweep: data = index
        for (int i = 0; i < 1024; i++) begin
            send(3'b001, {32'd0, BASE + 32'(i * 4)}, 11'd1, 32'(i), 8'h00, 16'h0000);
        end
        for (int i = 0; i < 1024; i++) begin
            read_expect("sweep", 3'b000, {32'd0, BASE + 32'(i * 4)}, 11'd1, 8'(i), 16'h1234,
                        2, 1'b1, 3'b000, 32'(i));
        end
        chk("sweep_err_count", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_responder.md
PIO_RESPONDER -- requirements
Module: pio_responder

Interface
REQ-001 BAR_A_BASE, 32'h1000_0000, BAR base address; 32-bit aligned window start.
REQ-002 BAR_A_SIZE, 1024, BAR window size in DW; power of two, 16 to 4096.
REQ-003 user_clk  in  1  sole clock; one clock domain; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 user_lnk_up  in  1  PCIe link up.
REQ-006 req_valid  in  1  decoded request TLP valid.
REQ-007 req_ready  out  1  responder accepts the request this cycle.
REQ-008 req_type  in  3  000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64, others unsupported.
REQ-009 req_tag  in  8  request tag.
REQ-010 req_rid  in  16  requester ID.
REQ-011 req_addr  in  64  byte address.
REQ-012 req_length  in  11  length in DW.
REQ-013 req_data  in  32  write payload DW0.
REQ-014 cpl_start  out  1  one-cycle pulse that launches the completion generator.
REQ-015 cpl_type  out  1  0 Cpl (no data), 1 CplD.
REQ-016 cpl_status  out  3  000 SC, 001 UR.
REQ-017 cpl_tag  out  8  echoed tag.
REQ-018 cpl_rid  out  16  echoed requester ID.
REQ-019 cpl_lower_addr  out  7  req_addr[6:0] of the read.
REQ-020 cpl_data  out  32  read data; 0 when cpl_type=0.
REQ-021 cpl_done  in  1  completion generator finished transmitting.
REQ-022 err_count  out  16  count of dropped or UR requests; saturates at 16'hFFFF.

Function
REQ-023 FSM states SHALL be ST_IDLE, ST_MEM_RD, ST_CPL and ST_CPL_WAIT.
REQ-024 req_ready SHALL equal (state==ST_IDLE && user_lnk_up); a request is accepted on req_valid && req_ready.
REQ-025 A request SHALL be a hit when req_addr[63:32]==0, BAR_A_BASE <= req_addr[31:0] < BAR_A_BASE+4*BAR_A_SIZE, and req_length==1.
REQ-026 The memory index SHALL be (req_addr[31:0]-BAR_A_BASE)>>2; req_addr[1:0] is ignored.
REQ-027 A hit write SHALL store req_data at the index in the accept cycle, generate no completion, and leave the FSM in ST_IDLE; back-to-back writes run at one per cycle.
REQ-028 A non-hit write or an unsupported req_type SHALL be dropped with err_count+1 and no completion.
REQ-029 On acceptance, a read SHALL capture tag, rid and addr[6:0]; a hit read goes to ST_MEM_RD, which has a 1-cycle registered memory read, then to ST_CPL with CplD, status SC and the memory data.
REQ-030 A non-hit read SHALL go directly to ST_CPL with Cpl, status UR and cpl_data 0, and increment err_count.
REQ-031 For a read accepted in cycle N, cpl_start SHALL be high in cycle N+2 for a hit and N+1 for a UR.
REQ-032 cpl_start SHALL be high only during ST_CPL; the FSM then enters ST_CPL_WAIT and returns to ST_IDLE on cpl_done.
REQ-033 cpl_done SHALL be ignored outside ST_CPL_WAIT, including when it coincides with cpl_start.
REQ-034 All cpl_* outputs except cpl_start SHALL hold stable from cpl_start until the cycle after cpl_done.
REQ-035 A write followed immediately by a read to the same index SHALL return the new data.
REQ-036 When user_lnk_up is low, the FSM SHALL go to ST_IDLE on the next edge and abandon any pending completion; memory and err_count are preserved.

Reset
REQ-037 On reset, the FSM SHALL enter ST_IDLE and req_ready, cpl_start, cpl_type, cpl_status, cpl_tag, cpl_rid, cpl_lower_addr, cpl_data and err_count SHALL all be 0.
REQ-038 Reset mid-completion SHALL abandon the completion; memory contents are not reset and are undefined until written.

Structure
REQ-039 Shared package pio_pkg SHALL hold the req_type encodings, cpl_status codes, Cpl/CplD encodings and FSM state constants.
REQ-040 The BAR storage SHALL be the sub-module pio_bar_mem: single-port, BAR_A_SIZE x 32, registered read.

Verification
REQ-041 MemWr32 32'hDEAD_BEEF to BASE+0x10, then MemRd32 to BASE+0x10 with tag 0x05 -> cpl_start 2 cycles after accept; CplD, SC, tag 0x05, data DEADBEEF, lower_addr 0x10.
REQ-042 MemRd32 to BASE+4*BAR_A_SIZE -> cpl_start 1 cycle after accept; Cpl, UR, data 0; err_count=1.
REQ-043 MemWr32 with length 2 to BASE -> memory unchanged on readback; err_count increments; no cpl_start.
REQ-044 Hold cpl_done low 10 cycles with req_valid high -> req_ready=0 throughout; cpl fields stable; req_ready=1 the cycle after cpl_done.
REQ-045 Drop user_lnk_up during ST_CPL_WAIT -> ST_IDLE next cycle, no further cpl_start; after link returns, earlier writes read back intact.
REQ-046 Sweep all 1024 DW: write data=index, read each back -> every CplD is SC with matching data; err_count=0.
